// File: rtl/wavelet_frame_serializer.sv
// Scans every wavelet filter-bank channel through the output multiplexer on each
// trigger, then ships a header/data/checksum frame out as 8N1 UART on o_tx.
module wavelet_frame_serializer #(
    parameter int                        NUM_CHANNELS   = 8,
    parameter int                        SUM_TRUNCATION = 8,
    parameter int                        SETTLE_CYCLES  = 2,
    parameter int                        CLKS_PER_BIT   = 16,
    parameter logic [SUM_TRUNCATION-1:0] HEADER_BYTE    = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_trigger,
    input  logic [SUM_TRUNCATION-1:0] i_wavelet,
    output logic [7:0]                o_select_channel,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic [7:0]                o_overrun_count
);

    localparam int W = SUM_TRUNCATION;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_DONE
    } state_t;

    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [7:0]  LAST_CH     = 8'(NUM_CHANNELS - 1);
    localparam logic [8:0]  LAST_BYTE   = 9'(NUM_CHANNELS + 1);
    localparam logic [7:0]  LAST_DBIT   = 8'(W - 1);
    // With a one-cycle settle the capture edge is the first edge after the select change.
    localparam state_t      SETTLE_ENTRY = (SETTLE_CYCLES > 1) ? S_SETTLE : S_CAPTURE;

    state_t         state_q;
    logic [15:0]    tmr_q;
    logic [7:0]     sel_q;
    logic [8:0]     byte_q;
    logic [7:0]     bit_q;
    logic [W-1:0]   shift_q;
    logic [W-1:0]   csum_q;
    logic [W-1:0]   buf_q [NUM_CHANNELS];
    logic           tx_q;
    logic           busy_q;
    logic           done_q;
    logic [7:0]     ovr_q;

    logic [W-1:0]   cur_byte;
    logic [7:0]     ovr_d;
    logic           bit_end;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        cur_byte = HEADER_BYTE;
        if (byte_q == LAST_BYTE) cur_byte = csum_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (byte_q == 9'(i + 1)) cur_byte = buf_q[i];
        end
        ovr_d   = (i_trigger && busy_q) ? sat_inc8(ovr_q) : ovr_q;
        bit_end = (tmr_q == BIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sel_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) buf_q[i] <= '0;
        end else begin
            ovr_q  <= ovr_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (i_trigger) begin
                        state_q <= SETTLE_ENTRY;
                        sel_q   <= '0;
                        tmr_q   <= '0;
                        busy_q  <= 1'b1;
                        csum_q  <= HEADER_BYTE;
                    end
                end
                S_SETTLE: begin
                    tmr_q <= tmr_q + 16'd1;
                    if (tmr_q == SETTLE_LAST) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (sel_q == 8'(i)) buf_q[i] <= i_wavelet;
                    end
                    csum_q <= csum_q ^ i_wavelet;
                    tmr_q  <= '0;
                    if (sel_q == LAST_CH) begin
                        sel_q   <= '0;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_TX_START;
                    end else begin
                        sel_q   <= sel_q + 8'd1;
                        state_q <= SETTLE_ENTRY;
                    end
                end
                S_TX_START: begin
                    tmr_q <= tmr_q + 16'd1;
                    if (bit_end) begin
                        tmr_q   <= '0;
                        tx_q    <= cur_byte[0];
                        shift_q <= cur_byte >> 1;
                        bit_q   <= '0;
                        state_q <= S_TX_DATA;
                    end
                end
                S_TX_DATA: begin
                    tmr_q <= tmr_q + 16'd1;
                    if (bit_end) begin
                        tmr_q <= '0;
                        if (bit_q == LAST_DBIT) begin
                            tx_q    <= 1'b1;
                            state_q <= S_TX_STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 8'd1;
                        end
                    end
                end
                S_TX_STOP: begin
                    tmr_q <= tmr_q + 16'd1;
                    if (bit_end) begin
                        tmr_q <= '0;
                        if (byte_q == LAST_BYTE) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_q  <= byte_q + 9'd1;
                            tx_q    <= 1'b0;
                            state_q <= S_TX_START;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_select_channel = sel_q;
    assign o_tx             = tx_q;
    assign o_busy           = busy_q;
    assign o_frame_done     = done_q;
    assign o_overrun_count  = ovr_q;

endmodule

// File: tb/tb_wavelet_frame_serializer.sv
// Directed bench for wavelet_frame_serializer: UART-decodes the frames of a CPB=4
// instance and a CPB=16 instance and compares against hand-computed bytes.
module tb_wavelet_frame_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigA = 1'b0, trigB = 1'b0;
    logic [7:0] wavA = 8'h00;
    logic [7:0] wavB = 8'hFF;
    logic [7:0] selA, selB, ovrA, ovrB;
    logic txA, txB, busyA, busyB, doneA, doneB;

    always #5 clk = ~clk;

    wavelet_frame_serializer #(.CLKS_PER_BIT(4)) u_dut_a (
        .clk(clk), .rst(rst), .i_trigger(trigA), .i_wavelet(wavA),
        .o_select_channel(selA), .o_tx(txA), .o_busy(busyA),
        .o_frame_done(doneA), .o_overrun_count(ovrA)
    );

    wavelet_frame_serializer #(.CLKS_PER_BIT(16)) u_dut_b (
        .clk(clk), .rst(rst), .i_trigger(trigB), .i_wavelet(wavB),
        .o_select_channel(selB), .o_tx(txB), .o_busy(busyB),
        .o_frame_done(doneB), .o_overrun_count(ovrB)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered multiplexer model: mode 0 -> sel+1, mode 1 -> sel*0x13+0x80, mode 3 -> 0xEE.
    int wav_mode = 0;
    always @(posedge clk) begin
        case (wav_mode)
            0:       wavA <= selA + 8'd1;
            1:       wavA <= 8'(selA * 8'h13 + 8'h80);
            default: wavA <= 8'hEE;
        endcase
    end

    // UART receivers, sampling mid-bit on falling edges.
    logic [7:0] rxA[$];
    logic [7:0] rxB[$];
    logic [7:0] shA = 0, shB = 0;
    bit dactA = 0, dactB = 0;
    int dcA = 0, dcB = 0, stopbad = 0;

    always @(negedge clk) begin
        if (rst) dactA <= 0;
        else if (!dactA) begin
            if (!txA) begin dactA <= 1; dcA <= 1; end
        end else begin
            dcA <= dcA + 1;
            if (dcA % 4 == 2 && dcA / 4 >= 1 && dcA / 4 <= 8) shA <= {txA, shA[7:1]};
            if (dcA == 9 * 4 + 2) begin
                rxA.push_back(shA);
                if (!txA) stopbad <= stopbad + 1;
                dactA <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) dactB <= 0;
        else if (!dactB) begin
            if (!txB) begin dactB <= 1; dcB <= 1; end
        end else begin
            dcB <= dcB + 1;
            if (dcB % 16 == 8 && dcB / 16 >= 1 && dcB / 16 <= 8) shB <= {txB, shB[7:1]};
            if (dcB == 9 * 16 + 8) begin
                rxB.push_back(shB);
                dactB <= 0;
            end
        end
    end

    // Level-segment lengths of the CPB=16 line inside a frame.
    logic txB_prev = 1'b1;
    bit segv = 0;
    int runB = 0, segs = 0, segbad = 0;
    always @(negedge clk) begin
        txB_prev <= txB;
        if (rst) begin
            segv <= 0;
            runB <= 0;
        end else if (txB != txB_prev) begin
            if (segv) begin
                segs <= segs + 1;
                if (runB % 16 != 0) segbad <= segbad + 1;
            end
            segv <= 1;
            runB <= 1;
        end else begin
            runB <= runB + 1;
            if (doneB) segv <= 0;
        end
    end

    logic [7:0] EXP0[10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAD};
    logic [7:0] EXP1[10] = '{8'hA5, 8'h80, 8'h93, 8'hA6, 8'hB9, 8'hCC, 8'hDF, 8'hF2, 8'h05, 8'h4D};
    logic [7:0] EXPB[10] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5};

    task automatic check_frame(input string tag, input int base, input logic [7:0] exp[10]);
        logic [31:0] got;
        for (int i = 0; i < 10; i++) begin
            got = (base + i < rxA.size()) ? {24'h0, rxA[base + i]} : 32'hDEAD;
            check_val($sformatf("%s[%0d]", tag, i), got, {24'h0, exp[i]});
        end
    endtask

    int busy_n, done_n, tx_low_cap;
    logic first_busy;
    logic [7:0] sel_log[17];

    // ovr_mode 1: 3 pulses + 5-cycle hold mid-transmit; 3: 260-cycle hold.
    task automatic run_frame(input int mode, input int ovr_mode, input bit pre, input bit stop_at_done);
        int c = 0, done_at = 0;
        bit fin = 0;
        wav_mode = mode;
        if (!pre) begin @(negedge clk); trigA = 1'b1; end
        busy_n = 0; done_n = 0; tx_low_cap = 0;
        while (!fin && c < 3000) begin
            @(negedge clk);
            c++;
            if (busyA) busy_n++;
            if (c == 1) first_busy = busyA;
            if (c <= 17) sel_log[c - 1] = selA;
            if (c <= 16 && !txA) tx_low_cap++;
            if (c == 17) wav_mode = 3;
            if (doneA) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            trigA = (ovr_mode == 1 && (c == 100 || c == 110 || c == 120 || (c >= 200 && c < 205)))
                 || (ovr_mode == 3 && c >= 20 && c < 280)
                 || (stop_at_done && doneA);
            if (done_at > 0 && (stop_at_done || c >= done_at + 2)) fin = 1;
        end
        check_val("frame_end", fin, 1);
    endtask

    initial begin
        int base, nd;
        bit finB;

        repeat (3) @(negedge clk);
        check_val("rst_tx", txA, 1);
        check_val("rst_sel", selA, 0);
        check_val("rst_busy", busyA, 0);
        check_val("rst_done", doneA, 0);
        check_val("rst_ovr", ovrA, 0);
        rst = 1'b0;

        // Basic frame plus capture-select timing.
        base = rxA.size();
        run_frame(0, 0, 0, 0);
        check_val("basic_busy", busy_n, 416);
        check_val("basic_done", done_n, 1);
        check_val("basic_txcap", tx_low_cap, 0);
        for (int i = 0; i < 17; i++)
            check_val($sformatf("sel[%0d]", i), sel_log[i], (i < 16) ? i / 2 : 0);
        check_frame("basic", base, EXP0);
        check_val("basic_len", rxA.size() - base, 10);
        check_val("basic_ovr", ovrA, 0);

        // Overrun while transmitting.
        base = rxA.size();
        run_frame(0, 1, 0, 0);
        check_val("ovr_count", ovrA, 8);
        check_val("ovr_busy", busy_n, 416);
        check_frame("ovr", base, EXP0);

        // Back-to-back: trigger held in the done cycle.
        base = rxA.size();
        run_frame(0, 0, 0, 1);
        check_val("b2b_done1", done_n, 1);
        check_val("b2b_txdone", txA, 1);
        run_frame(1, 0, 1, 0);
        check_val("b2b_start", first_busy, 1);
        check_val("b2b_sel0", sel_log[0], 0);
        check_val("b2b_txgap", tx_low_cap, 0);
        check_val("b2b_done2", done_n, 1);
        check_val("b2b_ovr", ovrA, 8);
        check_frame("b2b_f1", base, EXP0);
        check_frame("b2b_f2", base + 10, EXP1);
        check_val("b2b_len", rxA.size() - base, 20);

        // Saturating overrun count.
        base = rxA.size();
        run_frame(1, 3, 0, 0);
        check_val("sat_ovr", ovrA, 255);
        check_frame("sat", base, EXP1);

        // Reset during data bit 3 of byte 2.
        wav_mode = 0;
        @(negedge clk);
        trigA = 1'b1;
        for (int c = 1; c <= 113; c++) begin
            @(negedge clk);
            trigA = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_tx", txA, 1);
        check_val("mrst_busy", busyA, 0);
        check_val("mrst_sel", selA, 0);
        check_val("mrst_ovr", ovrA, 0);
        check_val("mrst_done", doneA, 0);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            if (doneA) nd++;
        end
        check_val("mrst_nodone", nd, 0);
        base = rxA.size();
        run_frame(0, 0, 0, 0);
        check_val("post_busy", busy_n, 416);
        check_frame("post", base, EXP0);
        check_val("post_len", rxA.size() - base, 10);
        check_val("stop_bits", stopbad, 0);

        // CPB=16 instance, all channels 0xFF.
        @(negedge clk);
        trigB = 1'b1;
        @(negedge clk);
        trigB = 1'b0;
        finB = 0;
        for (int c = 0; c < 2500 && !finB; c++) begin
            @(negedge clk);
            if (doneB) finB = 1;
        end
        check_val("b16_end", finB, 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++)
            check_val($sformatf("b16[%0d]", i), (i < rxB.size()) ? {24'h0, rxB[i]} : 32'hDEAD, {24'h0, EXPB[i]});
        check_val("b16_len", rxB.size(), 10);
        check_val("b16_segbad", segbad, 0);
        check_val("b16_segs_seen", segs > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
